// File: rtl/processor_core.sv
// -----------------------------------------------------------------------------
// processor_core
//
// Single-cycle 32-bit core. Each rising clk edge retires exactly one
// instruction: decode, register read, ALU, memory access and writeback all
// settle combinationally within the cycle and commit on the edge.
//
// Instruction word:
//   [31:25] reserved (ignored)
//   [24] J  jump         [23] W  store        [22] L  load
//   [21] I  immediate    [20] Z  conditional
//   [19:15] A  rd / store source / jump condition register
//   [14:10] B  imm5 or second source register
//   [9:5]   C  first source register (base for memory / jump target)
//   [4:0]   D  ALU operation
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   insn       instruction word read combinationally at address pc
//   pc         program counter (word address)
//   m_w        data-memory write enable (combinational, store only)
//   data_out   store data, always R[A]
//   data_in    load data returned combinationally by data memory
//   data_addr  data-memory word address, always R[C] + zext(B)
// -----------------------------------------------------------------------------
module processor_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] insn,
    output logic [31:0] pc,
    output logic        m_w,
    output logic [31:0] data_out,
    input  logic [31:0] data_in,
    output logic [31:0] data_addr
);

    // ALU operation codes; anything outside this set executes as add.
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_SLL = 5'd5;
    localparam logic [4:0] OP_SRL = 5'd6;
    localparam logic [4:0] OP_SLT = 5'd7;

    // Pure ALU: modulo-2^32 arithmetic, shifts use only the low five bits of y.
    function automatic logic [31:0] alu_f(
        input logic [4:0]  op,
        input logic [31:0] x,
        input logic [31:0] y
    );
        logic [31:0] r;
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLL:  r = x << y[4:0];
            OP_SRL:  r = x >> y[4:0];
            OP_SLT:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: r = x + y;
        endcase
        return r;
    endfunction

    // Architectural state.
    logic [31:0] pc_r;
    logic [31:0] rf_r [32];

    // Decoded fields.
    logic        j_s;
    logic        w_s;
    logic        l_s;
    logic        i_s;
    logic        z_s;
    logic [4:0]  a_s;
    logic [4:0]  b_s;
    logic [4:0]  c_s;
    logic [4:0]  d_s;
    logic        unused_s;

    // Datapath signals.
    logic [31:0] a_val_s;
    logic [31:0] b_val_s;
    logic [31:0] x_s;
    logic [31:0] y_s;
    logic [31:0] imm_s;
    logic [31:0] eff_addr_s;
    logic [31:0] alu_res_s;
    logic        is_store_s;
    logic        is_load_s;
    logic        is_alu_s;
    logic        taken_s;
    logic        wb_en_s;
    logic [31:0] wb_data_s;
    logic [31:0] next_pc_s;

    assign j_s = insn[24];
    assign w_s = insn[23];
    assign l_s = insn[22];
    assign i_s = insn[21];
    assign z_s = insn[20];
    assign a_s = insn[19:15];
    assign b_s = insn[14:10];
    assign c_s = insn[9:5];
    assign d_s = insn[4:0];

    // Reserved bits carry no meaning; fold them away explicitly.
    assign unused_s = ^insn[31:25];

    // Register file read ports; r0 is hard-wired to zero on every port.
    always_comb begin
        a_val_s = 32'd0;
        b_val_s = 32'd0;
        x_s     = 32'd0;
        if (a_s != 5'd0) begin
            a_val_s = rf_r[a_s];
        end else begin
            a_val_s = 32'd0;
        end
        if (b_s != 5'd0) begin
            b_val_s = rf_r[b_s];
        end else begin
            b_val_s = 32'd0;
        end
        if (c_s != 5'd0) begin
            x_s = rf_r[c_s];
        end else begin
            x_s = 32'd0;
        end
    end

    assign imm_s      = {27'd0, b_s};
    // Memory address and jump target share the same base+offset adder.
    assign eff_addr_s = x_s + imm_s;

    // Operand Y selection and ALU evaluation.
    always_comb begin
        y_s = 32'd0;
        if (i_s) begin
            y_s = imm_s;
        end else begin
            y_s = b_val_s;
        end
        alu_res_s = alu_f(d_s, x_s, y_s);
    end

    // Instruction class: J overrides W and L, and W overrides L.
    always_comb begin
        is_store_s = 1'b0;
        is_load_s  = 1'b0;
        is_alu_s   = 1'b0;
        if (j_s) begin
            is_store_s = 1'b0;
            is_load_s  = 1'b0;
            is_alu_s   = 1'b0;
        end else if (w_s) begin
            is_store_s = 1'b1;
        end else if (l_s) begin
            is_load_s  = 1'b1;
        end else begin
            is_alu_s   = 1'b1;
        end
    end

    // Branch resolution: unconditional, or conditional on R[A] being zero.
    always_comb begin
        taken_s = 1'b0;
        if (j_s) begin
            taken_s = (~z_s) | (a_val_s == 32'd0);
        end else begin
            taken_s = 1'b0;
        end
        if (taken_s) begin
            next_pc_s = eff_addr_s;
        end else begin
            next_pc_s = pc_r + 32'd1;
        end
    end

    // Writeback selection; writes aimed at r0 are dropped here.
    always_comb begin
        wb_en_s   = 1'b0;
        wb_data_s = alu_res_s;
        if (is_load_s) begin
            wb_data_s = data_in;
        end else begin
            wb_data_s = alu_res_s;
        end
        if ((is_load_s | is_alu_s) && (a_s != 5'd0)) begin
            wb_en_s = 1'b1;
        end else begin
            wb_en_s = 1'b0;
        end
    end

    // Program counter; wraps naturally through 32-bit addition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= 32'd0;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // Register file write port; reset clears every entry and aborts any write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= 32'd0;
            end
        end else if (wb_en_s) begin
            rf_r[a_s] <= wb_data_s;
        end
    end

    assign pc        = pc_r;
    assign data_addr = eff_addr_s;
    assign data_out  = a_val_s;
    // Gating with rst_n makes the write enable collapse the instant reset asserts.
    assign m_w       = is_store_s & rst_n;

endmodule

// File: tb/tb_processor_core.sv
module tb_processor_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        m_w;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic [31:0] data_addr;

    logic [31:0] imem [64];
    logic [31:0] bank [64];
    logic        mem_clr = 1'b0;
    logic        mon_en  = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        mw;
        logic [31:0] addr;
        logic [31:0] dout;
    } exp_t;
    exp_t exp_q [$];

    // reference model state
    logic [31:0] m_rf  [32];
    logic [31:0] m_mem [64];
    logic [31:0] m_pc;

    processor_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .insn      (insn),
        .pc        (pc),
        .m_w       (m_w),
        .data_out  (data_out),
        .data_in   (data_in),
        .data_addr (data_addr)
    );

    always #5 clk = ~clk;

    assign insn    = imem[pc[5:0]];
    assign data_in = bank[data_addr[5:0]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) bank[i] <= 32'd0;
        end else if (m_w) begin
            bank[data_addr[5:0]] <= data_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Executes n instructions from the spec rules, recording per-cycle outputs.
    task automatic model_run(input int n);
        for (int s = 0; s < n; s++) begin
            logic [31:0] w, x, y, r, addr, a_v;
            logic [4:0]  fa, fb, fc, fd;
            exp_t e;
            w  = imem[m_pc[5:0]];
            fa = w[19:15]; fb = w[14:10]; fc = w[9:5]; fd = w[4:0];
            x   = m_rf[fc];
            a_v = m_rf[fa];
            y   = w[21] ? 32'(fb) : m_rf[fb];
            addr = x + 32'(fb);
            case (fd)
                5'd1:    r = x - y;
                5'd2:    r = x & y;
                5'd3:    r = x | y;
                5'd4:    r = x ^ y;
                5'd5:    r = x << y[4:0];
                5'd6:    r = x >> y[4:0];
                5'd7:    r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                default: r = x + y;
            endcase
            e.pc = m_pc; e.mw = w[23] && !w[24]; e.addr = addr; e.dout = a_v;
            exp_q.push_back(e);
            if (w[24]) begin
                if (!w[20] || a_v == 32'd0) m_pc = addr;
                else m_pc = m_pc + 32'd1;
            end else if (w[23]) begin
                m_mem[addr[5:0]] = a_v;
                m_pc = m_pc + 32'd1;
            end else if (w[22]) begin
                m_rf[fa] = m_mem[addr[5:0]];
                m_pc = m_pc + 32'd1;
            end else begin
                m_rf[fa] = r;
                m_pc = m_pc + 32'd1;
            end
            m_rf[0] = 32'd0;
        end
    endtask

    // Reset the DUT with the current program loaded, then let the monitor
    // compare n cycles against the model.
    task automatic run_phase(input string tag, input int n);
        int b;
        rst_n = 1'b0;
        mem_clr = 1'b1;
        @(posedge clk);
        #1;
        mem_clr = 1'b0;
        chk({tag, " reset pc"}, pc, 32'd0);
        chk({tag, " reset m_w"}, {31'd0, m_w}, 32'd0);
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
        m_pc = 32'd0;
        model_run(n);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mon_en = 1'b1;
        b = 0;
        while (exp_q.size() > 0 && b < n + 10) begin
            @(posedge clk);
            b++;
        end
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d entries left, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    endtask

    // Monitor: compare DUT outputs against the scoreboard every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL monitor: no expected entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc", pc, e.pc);
                    chk("m_w", {31'd0, m_w}, {31'd0, e.mw});
                    chk("data_addr", data_addr, e.addr);
                    chk("data_out", data_out, e.dout);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_mw;
        clear_imem();

        // addi r1, r0, 1 then probe r1 through data_out
        imem[0] = 32'h00208400;
        imem[1] = 32'h00008000;
        run_phase("addi", 3);

        // all NOPs: pc counts 0..10
        clear_imem();
        run_phase("nop", 11);

        // r1=7; store r1 -> [5]; load [5] -> r2; probe r2
        clear_imem();
        imem[0] = 32'h00209C00;
        imem[1] = 32'h00809400;
        imem[2] = 32'h00411400;
        imem[3] = 32'h00010000;
        run_phase("ldst", 5);

        // unconditional jump to 3
        clear_imem();
        imem[0] = 32'h01000C00;
        run_phase("jmp", 3);

        // conditional jumps: not taken on r1=1, taken on r0
        clear_imem();
        imem[0] = 32'h00208400;
        imem[1] = 32'h01108C00;
        imem[2] = 32'h01100C00;
        run_phase("cjmp", 5);

        // jump to 0xFFFFFFFF then wrap to 0
        clear_imem();
        imem[0] = 32'h00208400;
        imem[1] = 32'h00010401;
        imem[2] = 32'h01000040;
        run_phase("wrap", 6);

        // write to r0 discarded; store r0 and load+store both set acts as store
        clear_imem();
        imem[0] = 32'h00202400;
        imem[1] = 32'h00800000;
        imem[2] = 32'h00209C00;
        imem[3] = 32'h00C09000;
        imem[4] = 32'h00011000;
        run_phase("r0", 6);

        // store loop, then reset in mid-cycle while a store is active
        clear_imem();
        imem[0] = 32'h00209C00;
        imem[1] = 32'h00809400;
        imem[2] = 32'h01000400;
        run_phase("loop", 5);
        #2;
        exp_mw = imem[m_pc[5:0]][23] & ~imem[m_pc[5:0]][24];
        chk("pre-reset pc", pc, m_pc);
        chk("pre-reset m_w", {31'd0, m_w}, {31'd0, exp_mw});
        rst_n = 1'b0;
        #1;
        chk("async reset pc", pc, 32'd0);
        chk("async reset m_w", {31'd0, m_w}, 32'd0);
        // after release, store from r1 must see r1 == 0
        clear_imem();
        imem[0] = 32'h00809400;
        run_phase("post", 3);

        // randomized programs
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 64; i++) begin
                logic [31:0] w;
                w = $urandom;
                w[24] = ($urandom_range(0, 7) == 0);
                w[23] = ($urandom_range(0, 5) == 0);
                w[22] = ($urandom_range(0, 4) == 0);
                w[4:0] = 5'($urandom_range(0, 9));
                imem[i] = w;
            end
            run_phase("rand", 300);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/processor_core.md
PROCESSOR_CORE -- requirements
Module: processor_core

Interface
REQ-001 The interface SHALL have one clock and an asynchronous, active-low reset, fixed as: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 insn  input  32  instruction word, combinationally read from instruction memory at address pc.
REQ-005 pc  output  32  program counter, a word address (not byte).
REQ-006 m_w  output  1  data-memory write enable, combinational.
REQ-007 data_out  output  32  store data driven to data memory.
REQ-008 data_in  input  32  load data returned combinationally by data memory.
REQ-009 data_addr  output  32  data-memory word address.

Function
REQ-010 The core SHALL be single-cycle, with one instruction per clk: decode, execute and commit on each rising edge.
REQ-011 The instruction format SHALL be:
- [31:25] reserved, ignored.
- [24] J (jump).
- [23] W (store).
- [22] L (load).
- [21] I (immediate).
- [20] Z (conditional).
- [19:15] A (rd / store source / condition reg).
- [14:10] B (imm5).
- [9:5] C (rs).
- [4:0] D (ALU op).
REQ-012 The register file SHALL hold 32 x 32-bit registers; r0 reads 0 always, and writes to r0 are discarded.
REQ-013 ALU operand X SHALL be R[C]; operand Y SHALL be zext(B) when I=1, otherwise R[B].
REQ-014 The ALU op codes D SHALL be:
- 0 add, 1 sub, 2 and, 3 or, 4 xor.
- 5 sll by Y[4:0], 6 srl by Y[4:0].
- 7 slt, signed, result 1/0.
- Any other code executes as add.
- Arithmetic is modulo 2^32.
REQ-015 Default instruction (J=W=L=0): R[A] <= ALU result at the clock edge.
REQ-016 Load (L=1, W=0, J=0):
- data_addr = R[C] + zext(B).
- R[A] <= data_in at the edge.
REQ-017 Store (W=1, J=0):
- data_addr = R[C] + zext(B).
- data_out = R[A].
- m_w = 1 for the whole cycle.
- No register write.
REQ-018 When both L and W are set, the instruction SHALL execute as a store.
REQ-019 Jump (J=1):
- Target = R[C] + zext(B).
- Taken if Z=0, or if Z=1 and R[A]==0.
- No register write; W and L are ignored.
REQ-020 Next pc SHALL be the jump target when a jump is taken, otherwise pc+1, wrapping 0xFFFFFFFF -> 0.
REQ-021 m_w SHALL be 0 for every instruction except a store.
REQ-022 data_addr and data_out SHALL always be driven from the A/B/C fields, even for non-memory instructions.
REQ-023 The all-zero instruction SHALL be a NOP (add r0,r0,r0) that only advances pc.
REQ-024 Companion memory contract:
- Word-addressed array named bank.
- Combinational read.
- Level-sensitive write while its write enable is high.
- Ports in order: write enable, address, write data, read data.
- The core relies on nothing beyond this contract.

Reset
REQ-025 While rst_n=0, the core SHALL hold:
- pc=0.
- All registers 0.
- m_w forced 0, asynchronously.
REQ-026 On rst_n deassertion, the first instruction SHALL execute from address 0 at the next rising edge.
REQ-027 Asserting reset mid-instruction SHALL abort that instruction: no register write, and m_w drops immediately.

Verification
REQ-028 Reset, then bank[0]=0x00208400 (I=1, A=1, B=1, D=add) -> after 1 edge, r1=1 and pc=1.
REQ-029 bank[0..10]=0 -> pc counts 0..10 on successive edges, m_w stays 0, registers unchanged.
REQ-030 Store to address 5 from r1, then load address 5 into r2:
- r1=7; store A=1, C=0, B=5 -> m_w=1, data_addr=5, data_out=7.
- Load A=2, C=0, B=5 -> r2=7.
REQ-031 Unconditional jump (J=1, Z=0, C=0, B=3) at pc 0 -> pc=3 next edge.
REQ-032 Conditional jump (J=1, Z=1, C=0, B=3):
- With R[A]=1 -> falls through, pc=1.
- With A=0 -> taken, pc=3.
REQ-033 After several instructions, assert rst_n=0 between edges -> pc=0 and m_w=0 immediately; r1 reads 0 after release.
